// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage between EXE and WB.
// Waits for load data, extends the addressed lane, selects write-back.
module mem_stage #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exe_to_mem_valid,
  output logic                       mem_allow_in,
  input  logic [PC_WIDTH+XLEN+11:0]  exe_to_mem_bus,
  input  logic                       dmem_rvalid,
  input  logic [XLEN-1:0]            dmem_rdata,
  input  logic                       wb_allow_in,
  output logic                       mem_to_wb_valid,
  output logic [PC_WIDTH+XLEN+6:0]   mem_to_wb_bus,
  output logic [XLEN+5:0]            mem_to_id_bypass_bus,
  output logic                       mem_load_pending
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [PC_WIDTH-1:0] w_in_pc;
  logic [XLEN-1:0]     w_in_alu;
  logic [1:0]          w_in_sel;
  logic                w_in_wen;
  logic [4:0]          w_in_waddr;
  logic [2:0]          w_in_ctrl;
  logic                w_in_ebrk;
  logic                w_in_load;

  logic                r_valid;
  logic [1:0]          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [XLEN-1:0]     r_alu;
  logic [1:0]          r_sel;
  logic                r_wen;
  logic [4:0]          r_waddr;
  logic [2:0]          r_ctrl;
  logic                r_ebrk;
  logic [XLEN-1:0]     r_hold;

  logic                w_ready_go;
  logic                w_accept;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [XLEN-1:0]     w_ext;
  logic [XLEN-1:0]     w_ld;
  logic [PC_WIDTH-1:0] w_pc4;
  logic [XLEN-1:0]     w_wdata;

  assign {w_in_pc, w_in_alu, w_in_sel, w_in_wen,
          w_in_waddr, w_in_ctrl, w_in_ebrk} = exe_to_mem_bus;

  assign w_in_load = (w_in_ctrl >= 3'd1) && (w_in_ctrl <= 3'd5);

  assign w_ready_go   = (r_state == S_WAIT) ? dmem_rvalid : 1'b1;
  assign mem_allow_in = !r_valid || (w_ready_go && wb_allow_in);
  assign w_accept     = mem_allow_in && exe_to_mem_valid;

  assign mem_to_wb_valid  = r_valid && w_ready_go;
  assign mem_load_pending = r_valid && (r_state == S_WAIT)
                            && !dmem_rvalid;

  // Lane extraction and sign/zero extension of the raw read word.
  always_comb begin
    w_byte = 8'h00;
    unique case (r_alu[1:0])
      2'd0: w_byte = dmem_rdata[7:0];
      2'd1: w_byte = dmem_rdata[15:8];
      2'd2: w_byte = dmem_rdata[23:16];
      2'd3: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_ext  = '0;
    unique case (r_ctrl)
      3'd1:    w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'd2:    w_ext = {{(XLEN-8){1'b0}}, w_byte};
      3'd3:    w_ext = {{(XLEN-16){w_half[15]}}, w_half};
      3'd4:    w_ext = {{(XLEN-16){1'b0}}, w_half};
      3'd5:    w_ext = dmem_rdata;
      default: w_ext = '0;
    endcase
  end

  assign w_pc4 = r_pc + PC_WIDTH'(4);
  assign w_ld  = (r_state == S_HOLD) ? r_hold : w_ext;

  // Write-back value select.
  always_comb begin
    w_wdata = r_alu;
    unique case (r_sel)
      2'd1:    w_wdata = w_ld;
      2'd2:    w_wdata = XLEN'(w_pc4);
      default: w_wdata = r_alu;
    endcase
  end

  assign mem_to_wb_bus = {r_pc, r_wen, r_waddr, w_wdata, r_ebrk};
  assign mem_to_id_bypass_bus = {r_wen & r_valid, r_waddr, w_wdata};

  // Stage valid bit follows EXE whenever MEM can take a new entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
    end else if (mem_allow_in) begin
      r_valid <= exe_to_mem_valid;
    end
  end

  // Pipeline register captures the EXE bundle on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= '0;
      r_alu   <= '0;
      r_sel   <= '0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_ctrl  <= '0;
      r_ebrk  <= 1'b0;
    end else if (w_accept) begin
      r_pc    <= w_in_pc;
      r_alu   <= w_in_alu;
      r_sel   <= w_in_sel;
      r_wen   <= w_in_wen;
      r_waddr <= w_in_waddr;
      r_ctrl  <= w_in_ctrl;
      r_ebrk  <= w_in_ebrk;
    end
  end

  // Load tracking: WAIT for data, HOLD captured data under WB stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (mem_allow_in) begin
      r_state <= (w_accept && w_in_load) ? S_WAIT : S_IDLE;
    end else if (r_valid && (r_state == S_WAIT) && dmem_rvalid) begin
      r_state <= S_HOLD;
    end
  end

  // Capture extended load data when it arrives but WB is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (!mem_allow_in && r_valid
                 && (r_state == S_WAIT) && dmem_rvalid) begin
      r_hold <= w_ext;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table plus scoreboard for mem_stage.
// Expected WB bundles are queued on accept and popped on retire.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_to_mem_valid;
  logic        mem_allow_in;
  logic [75:0] exe_to_mem_bus;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_allow_in;
  logic        mem_to_wb_valid;
  logic [70:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_bypass_bus;
  logic        mem_load_pending;

  logic [31:0] t_pc, t_alu, t_exp;
  logic [1:0]  t_sel;
  logic        t_wen, t_ebrk;
  logic [4:0]  t_waddr;
  logic [2:0]  t_ctrl;

  int checks = 0;
  int errors = 0;
  int retired = 0;
  logic [70:0] q[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [1:0]  sel;
    logic [2:0]  ctrl;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  assign exe_to_mem_bus = {t_pc, t_alu, t_sel, t_wen,
                           t_waddr, t_ctrl, t_ebrk};

  mem_stage #(.XLEN(32), .PC_WIDTH(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .exe_to_mem_valid     (exe_to_mem_valid),
    .mem_allow_in         (mem_allow_in),
    .exe_to_mem_bus       (exe_to_mem_bus),
    .dmem_rvalid          (dmem_rvalid),
    .dmem_rdata           (dmem_rdata),
    .wb_allow_in          (wb_allow_in),
    .mem_to_wb_valid      (mem_to_wb_valid),
    .mem_to_wb_bus        (mem_to_wb_bus),
    .mem_to_id_bypass_bus (mem_to_id_bypass_bus),
    .mem_load_pending     (mem_load_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop on retire, push on accept, flush on reset.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
    end else begin
      if (mem_to_wb_valid && wb_allow_in) begin
        retired++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected got %h want none",
                   mem_to_wb_bus);
        end else begin
          chk("wb_bus", 128'(mem_to_wb_bus), 128'(q.pop_front()));
        end
      end
      if (exe_to_mem_valid && mem_allow_in)
        q.push_back({t_pc, t_wen, t_waddr, t_exp, t_ebrk});
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] alu,
                      input logic [1:0] sel, input logic [2:0] ctrl,
                      input logic [31:0] exp, input logic ebrk);
    int n;
    t_pc = pc;
    t_alu = alu;
    t_sel = sel;
    t_ctrl = ctrl;
    t_exp = exp;
    t_ebrk = ebrk;
    t_wen = 1'b1;
    t_waddr = t_waddr + 5'd1;
    exe_to_mem_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (mem_allow_in) break;
      n++;
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got 0 want 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    exe_to_mem_valid = 1'b0;
  endtask

  logic [70:0] snap;
  int r0;

  initial begin
    tbl[0]  = '{32'h100, 32'h1, 2'd1, 3'd1, 32'h8081F2F3, 32'hFFFFFFF2};
    tbl[1]  = '{32'h104, 32'h3, 2'd1, 3'd2, 32'h8081F2F3, 32'h00000080};
    tbl[2]  = '{32'h108, 32'h2, 2'd1, 3'd3, 32'h8081F2F3, 32'hFFFF8081};
    tbl[3]  = '{32'h10C, 32'h0, 2'd1, 3'd4, 32'h8081F2F3, 32'h0000F2F3};
    tbl[4]  = '{32'h110, 32'h100, 2'd1, 3'd5, 32'h8081F2F3, 32'h8081F2F3};
    tbl[5]  = '{32'h114, 32'h3, 2'd1, 3'd3, 32'h8081F2F3, 32'hFFFF8081};
    tbl[6]  = '{32'h118, 32'h1, 2'd1, 3'd3, 32'h00008000, 32'hFFFF8000};
    tbl[7]  = '{32'hFFFFFFFC, 32'h9, 2'd2, 3'd0, 32'h0, 32'h00000000};
    tbl[8]  = '{32'h1000, 32'hABC, 2'd2, 3'd0, 32'h0, 32'h00001004};
    tbl[9]  = '{32'h120, 32'h5555AAAA, 2'd3, 3'd6, 32'h0, 32'h5555AAAA};
    tbl[10] = '{32'h124, 32'h13572468, 2'd0, 3'd7, 32'h0, 32'h13572468};
    tbl[11] = '{32'h128, 32'h40, 2'd0, 3'd5, 32'h77777777, 32'h00000040};

    rst = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    wb_allow_in = 1'b1;
    t_pc = 32'h200;
    t_alu = 32'h99;
    t_sel = 2'd0;
    t_wen = 1'b1;
    t_waddr = 5'd3;
    t_ctrl = 3'd0;
    t_ebrk = 1'b0;
    t_exp = 32'h99;
    exe_to_mem_valid = 1'b1;

    repeat (2) begin
      @(negedge clk);
      chk("rst_wb_valid", 128'(mem_to_wb_valid), 128'(0));
      chk("rst_allow_in", 128'(mem_allow_in), 128'(1));
      chk("rst_wb_bus", 128'(mem_to_wb_bus), 128'(0));
      chk("rst_byp_wen", 128'(mem_to_id_bypass_bus[37]), 128'(0));
      chk("rst_pending", 128'(mem_load_pending), 128'(0));
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rel_wb_valid", 128'(mem_to_wb_valid), 128'(0));
    @(posedge clk);
    #1 exe_to_mem_valid = 1'b0;
    @(negedge clk);
    chk("first_valid", 128'(mem_to_wb_valid), 128'(1));
    chk("bypass", 128'(mem_to_id_bypass_bus),
        128'({1'b1, 5'd3, 32'h99}));
    @(posedge clk);
    #1;

    r0 = retired;
    for (int i = 0; i < 4; i++) begin
      t_pc = 32'h300 + 32'(4 * i);
      t_alu = 32'h11 * 32'(i + 1);
      t_exp = t_alu;
      t_sel = 2'd0;
      t_ctrl = 3'd0;
      t_waddr = t_waddr + 5'd1;
      exe_to_mem_valid = 1'b1;
      @(negedge clk);
      chk("stream_allow", 128'(mem_allow_in), 128'(1));
      if (i > 0)
        chk("stream_valid", 128'(mem_to_wb_valid), 128'(1));
      @(posedge clk);
      #1;
    end
    exe_to_mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stream_count", 128'(retired - r0), 128'(4));

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].pc, tbl[i].alu, tbl[i].sel, tbl[i].ctrl,
           tbl[i].exp, i == 9);
      if (tbl[i].ctrl >= 3'd1 && tbl[i].ctrl <= 3'd5) begin
        dmem_rvalid = 1'b1;
        dmem_rdata = tbl[i].rdata;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
      end
    end
    @(posedge clk);
    #1;

    send(32'h400, 32'h200, 2'd1, 3'd5, 32'hA5A55A5A, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wait_pending", 128'(mem_load_pending), 128'(1));
      chk("wait_allow", 128'(mem_allow_in), 128'(0));
      @(posedge clk);
      #1;
    end
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hA5A55A5A;
    @(negedge clk);
    chk("wait_retire", 128'(mem_to_wb_valid), 128'(1));
    chk("wait_nopend", 128'(mem_load_pending), 128'(0));
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;

    wb_allow_in = 1'b0;
    send(32'h500, 32'h300, 2'd1, 3'd5, 32'h12345678, 1'b0);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h12345678;
    @(negedge clk);
    chk("hold_valid0", 128'(mem_to_wb_valid), 128'(1));
    chk("hold_allow0", 128'(mem_allow_in), 128'(0));
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("hold_valid", 128'(mem_to_wb_valid), 128'(1));
    chk("hold_data", 128'(mem_to_wb_bus[32:1]), 128'(32'h12345678));
    chk("hold_nopend", 128'(mem_load_pending), 128'(0));
    snap = mem_to_wb_bus;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hold_stable", 128'(mem_to_wb_bus), 128'(snap));
    @(posedge clk);
    #1 wb_allow_in = 1'b1;
    @(posedge clk);
    #1 dmem_rdata = '0;

    send(32'h600, 32'h44, 2'd1, 3'd5, 32'h0BADF00D, 1'b0);
    @(negedge clk);
    chk("rw_pending", 128'(mem_load_pending), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("rw_valid", 128'(mem_to_wb_valid), 128'(0));
    chk("rw_pend", 128'(mem_load_pending), 128'(0));
    chk("rw_allow", 128'(mem_allow_in), 128'(1));
    chk("rw_bus", 128'(mem_to_wb_bus), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("stray_valid", 128'(mem_to_wb_valid), 128'(0));
    chk("stray_pend", 128'(mem_load_pending), 128'(0));
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    send(32'h700, 32'h77, 2'd0, 3'd0, 32'h77, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 128'(q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
